// File: rtl/clock_monitor_if.sv
// ---------------------------------------------------------------------------
// clock_monitor_if
// Bundles the monitored signal, its configuration/clear controls and the
// measurement results of clock_monitor.
//   master : drives sig_in, exp_half, clr; observes the results
//   slave  : the monitor itself; observes sig_in/exp_half/clr, drives results
// Signals:
//   sig_in      1  monitored divided clock, treated as data
//   exp_half    4  expected half-period in clk cycles (0 never matches)
//   clr         1  synchronous clear of measurement state and sticky error
//   half_period 4  last measured half-period, saturated at 15
//   edge_cnt    8  detected sig_in edges since reset/clear (wraps)
//   locked      1  monitor is locked to the expected half-period
//   err         1  sticky error after a lock was lost
// ---------------------------------------------------------------------------
interface clock_monitor_if;
    logic       sig_in;
    logic [3:0] exp_half;
    logic       clr;
    logic [3:0] half_period;
    logic [7:0] edge_cnt;
    logic       locked;
    logic       err;

    modport master (
        output sig_in,
        output exp_half,
        output clr,
        input  half_period,
        input  edge_cnt,
        input  locked,
        input  err
    );

    modport slave (
        input  sig_in,
        input  exp_half,
        input  clr,
        output half_period,
        output edge_cnt,
        output locked,
        output err
    );
endinterface

// File: rtl/clock_monitor.sv
// ---------------------------------------------------------------------------
// clock_monitor
// Measures the half-period of a divided clock (sig_in, sampled as data) in
// clk cycles, counts its edges and locks once four consecutive measurements
// equal exp_half. A lost lock (wrong interval or a missing edge) latches a
// sticky error until clr or reset.
//
// Ports:
//   clk     input   system clock, all state changes on its rising edge
//   resetn  input   synchronous active-low reset
//   mon     slave   clock_monitor_if: sig_in, exp_half, clr in;
//                   half_period, edge_cnt, locked, err out
//
// Build option:
//   CLKMON_SYNC_EN  when defined, sig_in passes through a 2-flop synchronizer
//                   before the edge detector (2 extra cycles of latency,
//                   identical measured values). Undefined: sig_in is assumed
//                   synchronous to clk and feeds the detector directly.
// ---------------------------------------------------------------------------
module clock_monitor (
    input  logic            clk,
    input  logic            resetn,
    clock_monitor_if.slave  mon
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACQ    = 3'd1,
        S_TRACK  = 3'd2,
        S_LOCKED = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    // Consecutive matches required in TRACK before declaring lock
    localparam logic [2:0] LOCK_MATCHES = 3'd4;

    logic       sig_s_r;
    logic       sig_p_r;
    logic       edge_s;
    logic       match_s;
    logic       timeout_s;
    logic [3:0] run_cnt_r;
    logic [3:0] run_cnt_next_s;
    logic [2:0] match_cnt_r;
    state_t     state_r;
    logic [3:0] half_period_r;
    logic [7:0] edge_cnt_r;
    logic       locked_r;
    logic       err_r;

`ifdef CLKMON_SYNC_EN
    logic       sync1_r;
    logic       sync2_r;

    // Two-flop synchronizer for an asynchronous sig_in; not touched by clr
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= mon.sig_in;
            sync2_r <= sync1_r;
        end
    end

    // Edge-detector pipeline fed from the synchronizer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sig_s_r <= 1'b0;
            sig_p_r <= 1'b0;
        end else begin
            sig_s_r <= sync2_r;
            sig_p_r <= sig_s_r;
        end
    end
`else
    // Edge-detector pipeline fed directly from sig_in; not touched by clr
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sig_s_r <= 1'b0;
            sig_p_r <= 1'b0;
        end else begin
            sig_s_r <= mon.sig_in;
            sig_p_r <= sig_s_r;
        end
    end
`endif

    // Edge, comparison and next interval count
    always_comb begin
        edge_s    = sig_s_r ^ sig_p_r;
        // exp_half == 0 is an invalid expectation and must never match
        match_s   = (mon.exp_half != 4'd0) && (run_cnt_r == mon.exp_half);
        // Interval already longer than expected without an edge
        timeout_s = (run_cnt_r > mon.exp_half);
        run_cnt_next_s = run_cnt_r;
        if (edge_s) begin
            run_cnt_next_s = 4'd1;
        end else if (run_cnt_r == 4'd15) begin
            run_cnt_next_s = 4'd15;
        end else begin
            run_cnt_next_s = run_cnt_r + 4'd1;
        end
    end

    // Interval counter: cycles since the last edge (or since reset/clear)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_cnt_r <= 4'd0;
        end else if (mon.clr) begin
            run_cnt_r <= 4'd0;
        end else begin
            run_cnt_r <= run_cnt_next_s;
        end
    end

    // Lock FSM with measurement, edge counter and registered status outputs.
    // locked/err are written together with the state so they follow it
    // directly on the cycle after the transition.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= S_IDLE;
            match_cnt_r   <= 3'd0;
            half_period_r <= 4'd0;
            edge_cnt_r    <= 8'd0;
            locked_r      <= 1'b0;
            err_r         <= 1'b0;
        end else if (mon.clr) begin
            state_r       <= S_IDLE;
            match_cnt_r   <= 3'd0;
            half_period_r <= 4'd0;
            edge_cnt_r    <= 8'd0;
            locked_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            if (edge_s) begin
                edge_cnt_r <= edge_cnt_r + 8'd1;
            end

            case (state_r)
                S_IDLE: begin
                    // The partial interval before the first edge is not measured
                    if (edge_s) begin
                        state_r <= S_ACQ;
                    end
                end

                S_ACQ: begin
                    if (edge_s) begin
                        half_period_r <= run_cnt_r;
                        match_cnt_r   <= match_s ? 3'd1 : 3'd0;
                        state_r       <= S_TRACK;
                    end
                end

                S_TRACK: begin
                    if (edge_s) begin
                        half_period_r <= run_cnt_r;
                        if (!match_s) begin
                            match_cnt_r <= 3'd0;
                        end else if (match_cnt_r + 3'd1 >= LOCK_MATCHES) begin
                            match_cnt_r <= LOCK_MATCHES;
                            state_r     <= S_LOCKED;
                            locked_r    <= 1'b1;
                        end else begin
                            match_cnt_r <= match_cnt_r + 3'd1;
                        end
                    end
                end

                S_LOCKED: begin
                    if (edge_s) begin
                        half_period_r <= run_cnt_r;
                        if (!match_s) begin
                            state_r  <= S_ERR;
                            locked_r <= 1'b0;
                            err_r    <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        // Missing edge: the interval has outgrown exp_half
                        state_r  <= S_ERR;
                        locked_r <= 1'b0;
                        err_r    <= 1'b1;
                    end
                end

                S_ERR: begin
                    // Sticky: only clr/reset leave ERR, measurement continues
                    if (edge_s) begin
                        half_period_r <= run_cnt_r;
                    end
                end

                default: begin
                    state_r     <= S_IDLE;
                    match_cnt_r <= 3'd0;
                    locked_r    <= 1'b0;
                    err_r       <= 1'b0;
                end
            endcase
        end
    end

    assign mon.half_period = half_period_r;
    assign mon.edge_cnt    = edge_cnt_r;
    assign mon.locked      = locked_r;
    assign mon.err         = err_r;

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-low.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: resetn  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: sig_in  input  1  monitored divided clock (e.g. div-2/div-4 generator output), treated as data.
REQ-005 Port: exp_half  input  4  expected half-period of sig_in in clk cycles; 0 is invalid and never matches.
REQ-006 Port: clr  input  1  synchronous clear of measurement state and sticky error.
REQ-007 Port: half_period  output  4  last measured half-period in clk cycles, saturated at 15.
REQ-008 Port: edge_cnt  output  8  count of detected sig_in edges since reset/clr.
REQ-009 Port: locked  output  1  high while in LOCKED state.
REQ-010 Port: err  output  1  high while in ERR state (sticky).

Function
REQ-011 sig_s SHALL be sig_in registered once; sig_p SHALL be sig_s delayed one cycle; edge = sig_s XOR sig_p.
REQ-012 run_cnt (4 bit) SHALL load 1 on an edge cycle, otherwise increment, saturating at 15.
REQ-013 On an edge in ACQ, TRACK or LOCKED, half_period SHALL load run_cnt's pre-update value.
REQ-014 edge_cnt SHALL increment on every edge, wrapping 255 -> 0.
REQ-015 States SHALL be IDLE, ACQ, TRACK, LOCKED, ERR; match_cnt (3 bit) counts consecutive matches.
REQ-016 IDLE: first edge -> ACQ; the partial interval before it is not measured; half_period unchanged.
REQ-017 ACQ: edge -> TRACK, match_cnt = 1 if measurement == exp_half, else 0.
REQ-018 TRACK: matching edge increments match_cnt; on reaching 4 -> LOCKED; mismatch sets match_cnt = 0 and stays in TRACK.
REQ-019 LOCKED: mismatching edge -> ERR; run_cnt > exp_half with no edge (missing edge) -> ERR.
REQ-020 ERR SHALL hold until resetn low or clr high; edges are still counted and measured in ERR.
REQ-021 locked and err SHALL be registered decodes of state, valid the cycle after the transition.
REQ-022 A change of exp_half SHALL take effect on the next edge comparison; no implicit relock.
REQ-023 Priority: resetn > clr > edge/timeout events in the same cycle.
REQ-024 clr high SHALL force IDLE, match_cnt = 0, edge_cnt = 0, run_cnt = 0, half_period = 0; sig_s/sig_p keep sampling.

Reset
REQ-025 On resetn low at rising clk: state IDLE, half_period 0, edge_cnt 0, locked 0, err 0, run_cnt 0, match_cnt 0, sig_s 0, sig_p 0.
REQ-026 Reset asserted mid-measurement SHALL discard all progress; the first edge after release is treated as from IDLE.
REQ-027 An edge caused solely by reset clearing sig_s/sig_p SHALL NOT be counted (both clear together).

Configuration
REQ-028 Macro CLKMON_SYNC_EN: when defined, sig_in SHALL pass through a 2-flop synchronizer before sig_s, adding 2 cycles of edge latency; synchronizer flops reset to 0.
REQ-029 Without CLKMON_SYNC_EN, sig_in SHALL feed sig_s directly (sig_in assumed synchronous to clk); measured values are identical in both builds.

Verification
REQ-030 exp_half=1, sig_in toggles every clk -> locked=1 one cycle after 5th detected edge, half_period=1, err=0.
REQ-031 exp_half=2, sig_in toggles every 2 clk -> locked after 5th edge; then one held-high 3-cycle interval -> err=1, locked=0, half_period=3.
REQ-032 LOCKED at exp_half=2, sig_in stops toggling -> err=1 when run_cnt reaches 3; err persists until clr -> state IDLE, edge_cnt=0.
REQ-033 exp_half=0, sig_in toggles every clk for 20 edges -> locked never asserts, err=0, edge_cnt=20.
REQ-034 260 edges with no clr -> edge_cnt=4 (wrap); clr and edge in same cycle -> edge_cnt=0.
REQ-035 resetn low for one cycle while in TRACK with match_cnt=3 -> all outputs 0; relock requires 5 new edges.
